// File: rtl/multibyte_add_seq.sv
// Byte-serial wide adder controller: drives an external 8-bit ripple adder one byte per clock, LSB first.
// Optional MULTIBYTE_SUB_EN adds A-B via inverted B bytes and forced initial carry.
module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  cin,
  input  logic                  sub,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  ovf
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            sub_reg;
  logic [IDXW-1:0] idx;
  logic            carry;
  logic [7:0]      b_byte;

  // Two's-complement overflow: carry into the MSB differs from carry out of it.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb, input logic c_out);
    return a_msb ^ b_msb ^ s_msb ^ c_out;
  endfunction

  function automatic logic start_carry(input logic sub_req, input logic cin_req);
`ifdef MULTIBYTE_SUB_EN
    return sub_req ? 1'b1 : cin_req;
`else
    logic unused_sub;
    unused_sub = sub_req;
    return cin_req;
`endif
  endfunction

  assign b_byte = b_reg[{idx, 3'b000} +: 8];

  // Adder operands are live only in RUN so the adder sees zeros while idle.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[{idx, 3'b000} +: 8];
      add_b   = sub_reg ? ~b_byte : b_byte;
      add_cin = carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      sub_reg <= 1'b0;
      idx     <= '0;
      carry   <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= op_a;
            b_reg   <= op_b;
`ifdef MULTIBYTE_SUB_EN
            sub_reg <= sub;
`else
            sub_reg <= 1'b0;
`endif
            carry   <= start_carry(sub, cin);
            idx     <= '0;
            result  <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          result[{idx, 3'b000} +: 8] <= add_sum;
          carry <= add_cout;
          if (idx == LAST) begin
            cout  <= add_cout;
            ovf   <= signed_ovf(add_a[7], add_b[7], add_sum[7], add_cout);
            done  <= 1'b1;
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Randomized bench for multibyte_add_seq with an arithmetic reference model and directed literal checks.
// Define MULTIBYTE_SUB_EN for both files to exercise subtraction.
module tb_multibyte_add_seq;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [7:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         busy, done, cout, ovf;
  logic [W-1:0] result;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // The external 8-bit ripple adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

  multibyte_add_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .cin(cin), .sub(sub), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .busy(busy), .done(done),
    .result(result), .cout(cout), .ovf(ovf)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: ph = cycles since the accepting edge (1..NB RUN, NB+1 DONE, 0 idle).
  int           ph = 0;
  logic [W-1:0] ma = '0;
  logic [W-1:0] mbe = '0;
  logic         mcin = 1'b0;
  logic [W:0]   mfull = '0;
  logic         mcout = 1'b0;
  logic         movf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; ma = '0; mbe = '0; mcin = 1'b0; mfull = '0; mcout = 1'b0; movf = 1'b0;
    end else if (ph == 0) begin
      if (start) begin
        logic msub;
`ifdef MULTIBYTE_SUB_EN
        msub = sub;
`else
        msub = 1'b0;
`endif
        ma    = op_a;
        mbe   = msub ? ~op_b : op_b;
        mcin  = msub ? 1'b1 : cin;
        mfull = {1'b0, ma} + {1'b0, mbe} + {{W{1'b0}}, mcin};
        ph    = 1;
      end
    end else if (ph == NB + 1) begin
      ph = 0;
    end else begin
      ph = ph + 1;
      if (ph == NB + 1) begin
        mcout = mfull[W];
        movf  = (ma[W-1] == mbe[W-1]) && (mfull[W-1] != ma[W-1]);
      end
    end
  end

  function automatic longint unsigned low_mask(input int k);
    return (k == 0) ? 64'd0 : ((64'd1 << k) - 64'd1);
  endfunction

  logic [NB-1:0] cin_log = '0;

  always @(negedge clk) begin
    longint unsigned m, exp_res, csum;
    int k;
    if (ph >= 1 && ph <= NB) begin
      k = 8 * (ph - 1);
      m = low_mask(k);
      exp_res = longint'(mfull[W-1:0]) & m;
      csum = (longint'(ma) & m) + (longint'(mbe) & m) + longint'(mcin);
      chk("add_a", add_a, (longint'(ma) >> k) & 64'hFF);
      chk("add_b", add_b, (longint'(mbe) >> k) & 64'hFF);
      chk("add_cin", add_cin, (csum >> k) & 64'd1);
      cin_log[ph-1] <= add_cin;
    end else begin
      exp_res = longint'(mfull[W-1:0]);
      chk("add_idle", {add_a, add_b, add_cin}, 64'd0);
    end
    chk("busy", busy, ph != 0);
    chk("done", done, ph == NB + 1);
    chk("result", result, exp_res);
    chk("cout", cout, mcout);
    chk("ovf", ovf, movf);
  end

  int lat;

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s, input logic poke);
    @(posedge clk); #2;
    op_a = a; op_b = b; cin = c; sub = s; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    if (poke) begin
      @(posedge clk); #2;
      op_a = ~a; op_b = ~b; cin = ~c; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
    end
    lat = poke ? 2 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!done) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_result", result, 64'd0);
    chk("reset_flags", {busy, done, cout, ovf}, 64'd0);

    do_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b0);
    chk("carry_latency", lat, NB + 1);
    chk("carry_result", result, 64'h00000100);
    chk("carry_cout_ovf", {cout, ovf}, 64'd0);
    chk("carry_cin_seq", cin_log, 64'b0010);

    do_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0);
    chk("wrap_result", result, 64'h0);
    chk("wrap_cout_ovf", {cout, ovf}, 64'b10);

    do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
    chk("ovf_result", result, 64'h80000000);
    chk("ovf_cout_ovf", {cout, ovf}, 64'b01);

    do_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b1);
    chk("ignored_start_result", result, 64'h23456789);

`ifdef MULTIBYTE_SUB_EN
    do_op(32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b0);
    chk("sub_neg_result", result, 64'hFFFFFFFE);
    chk("sub_neg_cout", cout, 64'd0);
    do_op(32'h00000007, 32'h00000005, 1'b0, 1'b1, 1'b0);
    chk("sub_pos_result", result, 64'h2);
    chk("sub_pos_cout", cout, 64'd1);
`endif

    // Reset in cycle 2 of an operation.
    @(posedge clk); #2;
    op_a = 32'hA5A5A5A5; op_b = 32'h5A5A5A5B; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_result", result, 64'd0);
    chk("midreset_done_busy", {done, busy}, 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (NB + 3) @(negedge clk);
    chk("midreset_no_done", {done, result}, 64'd0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0: op_a = 32'hFFFFFFFF;
        1: op_a = 32'h7FFFFFFF;
        default: op_a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: op_b = 32'h00000000;
        1: op_b = 32'h80000000;
        default: op_b = $urandom;
      endcase
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 299) != 0);
    end
    @(posedge clk); #2;
    rst_n = 1'b1; start = 1'b0;
    repeat (NB + 3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multibyte_add_seq.md
# multibyte_add_seq

Sequential controller that performs NBYTES×8-bit additions on the team's 8-bit ripple-carry adder stage, one byte per clock, chaining the carry between bytes. It sits directly upstream and downstream of the adder. It drives the adder's operand and carry-in inputs from latched operands, and it collects the adder's sum and carry-out into a wide result register. A start/busy/done handshake lets the bus-side logic request wide adds without owning any arithmetic.

## Interface
- NBYTES, 4, number of byte slices per operation (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op_a  in  8*NBYTES  operand A, latched on accepted start
- op_b  in  8*NBYTES  operand B, latched on accepted start
- cin  in  1  initial carry-in, latched on accepted start
- sub  in  1  subtract request (effective only with MULTIBYTE_SUB_EN)
- add_a  out  8  byte of A to adder
- add_b  out  8  byte of B (or ~B) to adder
- add_cin  out  1  carry into adder
- add_sum  in  8  adder Sum, combinational from add_a/add_b/add_cin
- add_cout  in  1  adder Cout
- busy  out  1  high from accepted start through DONE
- done  out  1  one-cycle pulse, result valid
- result  out  8*NBYTES  wide sum
- cout  out  1  final carry-out
- ovf  out  1  signed overflow of wide operation

## Operation
- Reset: state IDLE, byte index 0, carry reg 0. result, cout, ovf, busy, done, add_a, add_b and add_cin are all 0.
- State IDLE: add_a/add_b/add_cin = 0.
  - start=1 → latch op_a, op_b, sub. Set carry reg = cin (sub mode: 1). Set idx=0, result=0. Go to RUN.
- State RUN: add_a = a_reg[8*idx +: 8], add_b = b_reg byte (inverted in sub mode), add_cin = carry reg.
  - Each clock: result[8*idx +: 8] ← add_sum; carry reg ← add_cout; idx ← idx+1.
  - When idx = NBYTES-1, also: cout ← add_cout; ovf ← a_msb ^ b_eff_msb ^ add_sum[7] ^ add_cout (carry into MSB XOR carry out); go to DONE.
- State DONE: done=1 for exactly one cycle, busy=1, then → IDLE.
- result/cout/ovf hold until the next accepted start. The accepted start clears result only; cout and ovf hold until overwritten at the final byte.
- busy = (state ≠ IDLE).
- start while busy is ignored and is not queued. start held high through DONE is first sampled in the following IDLE cycle.
- Arithmetic is modulo 2^(8*NBYTES). The carry out of each byte feeds only the next byte.
- idx width = clog2(NBYTES). idx never exceeds NBYTES-1.
- rst_n low mid-operation: immediate return to reset values. No done pulse and no partial result retained.

## Timing
- Accepted start on edge 0 → RUN during cycles 1..NBYTES → done high in cycle NBYTES+1.
- Total latency from start to done = NBYTES+1 clocks. Next start can be accepted in cycle NBYTES+2.
- The adder path is combinational within one cycle, with no register between add_* outputs and add_sum/add_cout.
- The sustained rate is one operation per NBYTES+2 cycles.
- Byte 0 (LSB) is processed first.

## Configuration
- MULTIBYTE_SUB_EN defined:
  - sub=1 at start selects A−B.
  - add_b = ~b_reg byte; initial carry = 1, and cin is ignored.
  - cout = 1 means no borrow. ovf uses the inverted B MSB.
- MULTIBYTE_SUB_EN undefined:
  - The sub input is unused and the block is add-only.
  - add_b is always the true B byte.

## Test plan
- Reset: hold rst_n=0, then release → all outputs 0, busy=0, done=0, state IDLE.
- NBYTES=4 carry chain: A=0x000000FF, B=0x00000001, cin=0 → done at cycle 5 with result=0x00000100, cout=0, ovf=0. add_cin shows 0,1,0,0 across RUN.
- Full wrap: A=0xFFFFFFFF, B=0x00000000, cin=1 → result=0x00000000, cout=1, ovf=0.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001, cin=0 → result=0x80000000, cout=0, ovf=1.
- start pulsed during RUN, and rst_n asserted in cycle 2 of a later op:
  - The ignored start leaves the operand and result unchanged.
  - The reset clears result to 0 and issues no done pulse.
- MULTIBYTE_SUB_EN build:
  - A=0x00000005, B=0x00000007, sub=1 → result=0xFFFFFFFE, cout=0.
  - A=7, B=5 → result=2, cout=1.
